bcd_scan_counter: RTL
=====================

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits counted and scanned; legal range 1..8.
REQ-002 Parameter TICK_DIV, default 50000000: clk cycles per count step; must be >= 2.
REQ-003 Parameter SCAN_DIV, default 50000: clk cycles each digit stays selected; must be >= 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pause  input  1  level; 1 freezes the count step prescaler.
REQ-007 up_dn  input  1  1 = count up, 0 = count down; sampled at each step.
REQ-008 load  input  1  single-cycle strobe; loads load_val into the counter.
REQ-009 load_val  input  4*DIGITS  BCD value to load; digit 0 in bits [3:0].
REQ-010 cnt_bcd  output  4*DIGITS  current registered BCD count.
REQ-011 wrap  output  1  one-cycle pulse on full-range wrap.
REQ-012 sel  output  DIGITS  active-low one-hot digit select.
REQ-013 data  output  8  active-low segments {dp,g,f,e,d,c,b,a} of the selected digit.
REQ-014 light  output  8  cnt_bcd[7:0]; upper bits are 0 when DIGITS = 1.

Function
REQ-015 Prescaler counts 0..TICK_DIV-1 while pause=0 and holds its value while pause=1.
- A step occurs in the cycle the prescaler equals TICK_DIV-1 with pause=0.
- The prescaler then returns to 0.
REQ-016 Up step: digit 0 increments; a digit at 9 becomes 0 and carries into the next digit.
REQ-017 Down step: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
REQ-018 Up step from all-9s gives all-0s; down step from all-0s gives all-9s.
- wrap=1 for exactly the cycle after that step; wrap=0 otherwise.
REQ-019 cnt_bcd updates on the clock edge ending the step cycle, so latency is 1 cycle.
REQ-020 load=1 takes priority over a step in the same cycle.
- cnt_bcd <= load_val next cycle; prescaler <= 0; no wrap.
- load acts even while pause=1.
REQ-021 A load_val digit greater than 9 is loaded as 9; digits are clamped independently.
REQ-022 Scan timer counts 0..SCAN_DIV-1 continuously; it is independent of pause and load.
- On reaching SCAN_DIV-1, digit index advances idx+1, with DIGITS-1 wrapping to 0.
REQ-023 sel and data are registered.
- sel = ~(1<<idx).
- data[6:0] = active-low pattern of digit idx: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (dp bit shown as 1).
REQ-024 data[7] (dp) = 0 only when idx = 0 and pause = 1; else 1.
REQ-025 Digit value and select are registered together, so sel and data always refer to the same idx (no ghosting cycle).
REQ-026 Changing up_dn between steps has no side effect; the next step uses the new direction.

Reset
REQ-027 rst_n=0 forces immediately, regardless of clk:
- cnt_bcd=0, prescaler=0, scan timer=0, idx=0, wrap=0.
- sel = all ones except bit0 = 0.
- data = 8'hC0; light = 0.
REQ-028 Reset asserted mid-step or mid-load discards the pending update; the first step after release needs a full TICK_DIV cycles.

Verification (DIGITS=4, TICK_DIV=4, SCAN_DIV=2)
REQ-029 Reset, then pause=0, up_dn=1 for 40 cycles -> cnt_bcd=0x0010 after 40 cycles (10 steps), light=0x10.
REQ-030 load_val=0x9999 with load=1, then up_dn=1 for 4 cycles -> cnt_bcd=0x0000 and wrap high for one cycle.
REQ-031 Count 0x0000 with up_dn=0, one step -> cnt_bcd=0x9999 and wrap pulse.
- Also: load_val=0x0A1F -> cnt_bcd=0x0919.
REQ-032 Hold pause=1 for 20 cycles mid-count -> cnt_bcd unchanged, sel keeps scanning 1110,1101,1011,0111 every 2 cycles, data[7]=0 while sel=1110.
REQ-033 load and a step in the same cycle -> cnt_bcd=load_val and the next step needs 4 cycles; rst_n pulsed low between clk edges -> outputs equal REQ-027 values at once.

Source files
------------

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a step prescaler, clamped parallel load
// and a multiplexed active-low seven-segment scan driver.
module bcd_scan_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pause,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt_bcd,
  output logic                  wrap,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            data,
  output logic [7:0]            light
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] SEL_RST = ~DIGITS'(1);

  logic [4*DIGITS-1:0] cnt_reg, cnt_next;
  logic [PW-1:0]       presc_reg, presc_next;
  logic                wrap_reg, wrap_next;
  logic [SW-1:0]       scan_reg, scan_next;
  logic [IW-1:0]       idx_reg, idx_next;
  logic [DIGITS-1:0]   sel_reg, sel_next;
  logic [7:0]          data_reg, data_next;

  logic [4*DIGITS-1:0] inc_val, dec_val, clamp_val;
  logic [DIGITS-1:0]   is9, is0;
  logic                step;
  logic [3:0]          shown_digit;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Carry/borrow into a digit is the AND of all lower digits being 9 (or 0),
  // formed from a mask so no combinational chain runs through one vector.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur, raw;
      logic       c_in, b_in;
      assign cur = cnt_reg[4*gi +: 4];
      assign raw = load_val[4*gi +: 4];
      assign is9[gi] = (cur == 4'd9);
      assign is0[gi] = (cur == 4'd0);
      assign c_in = &(is9 | ~DIGITS'((1 << gi) - 1));
      assign b_in = &(is0 | ~DIGITS'((1 << gi) - 1));
      assign inc_val[4*gi +: 4]   = !c_in ? cur : (is9[gi] ? 4'd0 : cur + 4'd1);
      assign dec_val[4*gi +: 4]   = !b_in ? cur : (is0[gi] ? 4'd9 : cur - 4'd1);
      assign clamp_val[4*gi +: 4] = (raw > 4'd9) ? 4'd9 : raw;
    end

    if (DIGITS == 1) begin : g_light1
      assign light = {4'b0000, cnt_reg[3:0]};
    end else begin : g_lightn
      assign light = cnt_reg[7:0];
    end
  endgenerate

  assign step = !pause && (presc_reg == PW'(TICK_DIV - 1));

  always_comb begin
    cnt_next   = cnt_reg;
    presc_next = presc_reg;
    wrap_next  = 1'b0;
    if (load) begin
      cnt_next   = clamp_val;
      presc_next = '0;
    end else if (step) begin
      presc_next = '0;
      cnt_next   = up_dn ? inc_val : dec_val;
      wrap_next  = up_dn ? (&is9) : (&is0);
    end else if (!pause) begin
      presc_next = presc_reg + 1'b1;
    end
  end

  always_comb begin
    scan_next = scan_reg + 1'b1;
    idx_next  = idx_reg;
    if (scan_reg == SW'(SCAN_DIV - 1)) begin
      scan_next = '0;
      idx_next  = (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end
  end

  // Select and segment data are built from the same next-state index and
  // count, so both registers always describe one digit.
  always_comb begin
    shown_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == IW'(i)) shown_digit = cnt_next[4*i +: 4];
    end
    sel_next  = ~(DIGITS'(1) << idx_next);
    data_next = {~((idx_next == '0) && pause), seg7(shown_digit)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      presc_reg <= '0;
      wrap_reg  <= 1'b0;
      scan_reg  <= '0;
      idx_reg   <= '0;
      sel_reg   <= SEL_RST;
      data_reg  <= 8'hC0;
    end else begin
      cnt_reg   <= cnt_next;
      presc_reg <= presc_next;
      wrap_reg  <= wrap_next;
      scan_reg  <= scan_next;
      idx_reg   <= idx_next;
      sel_reg   <= sel_next;
      data_reg  <= data_next;
    end
  end

  assign cnt_bcd = cnt_reg;
  assign wrap    = wrap_reg;
  assign sel     = sel_reg;
  assign data    = data_reg;

endmodule
